// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the dmem responder: FSM encodings, op codes, wait-state bound
// and the base-relative address helper.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = 4;

    // Unsigned 32-bit distance from the window base; wraps below the base so those
    // addresses land far out of range.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem request/accept channels between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        dmem_wready;
    logic        dmem_wvalid;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rready;
    logic        dmem_rvalid;
    logic [31:0] dmem_raddr;
    logic        dmem_rresp;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb, dmem_rready, dmem_raddr,
        input  dmem_wvalid, dmem_rvalid, dmem_rresp, dmem_rdata
    );

    modport slave (
        input  dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb, dmem_rready, dmem_raddr,
        output dmem_wvalid, dmem_rvalid, dmem_rresp, dmem_rdata
    );
endinterface

// File: rtl/dmem_responder_ram.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
// The array itself is not reset; only the read register is.
module dmem_responder_ram #(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic             rd_clr,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Byte-lane masked write
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register: loads on read accept, zero when the address missed the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= rd_clr ? 32'h0000_0000 : mem_r[idx];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// dmem target: write-priority grant, wait-state FSM, window decode and response register
// in front of the word RAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] DMEM_BASE   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 32'd0) ? 4'(WAIT_CYCLES - 32'd1) : 4'd0;

    state_e      state_r, state_s;
    op_e         op_r, op_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] acc_addr_s;
    logic [31:0] offset_s;
    logic        in_range_s;
    logic        op_ready_s;
    logic        wvalid_s, rvalid_s;
    logic        wacc_s, racc_s;
    logic        rresp_r;

    assign op_ready_s = (op_r == OP_WRITE) ? bus.dmem_wready : bus.dmem_rready;

    // Next-state and accept decode; the counter reaches zero on the cycle ACK is entered
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        cnt_s      = cnt_r;
        addr_s     = addr_r;
        acc_addr_s = addr_r;
        wvalid_s   = 1'b0;
        rvalid_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (WAIT_CYCLES == 32'd0) begin
                    if (bus.dmem_wready) begin
                        wvalid_s   = 1'b1;
                        acc_addr_s = bus.dmem_waddr;
                    end else if (bus.dmem_rready) begin
                        rvalid_s   = 1'b1;
                        acc_addr_s = bus.dmem_raddr;
                    end else begin
                        acc_addr_s = addr_r;
                    end
                end else if (bus.dmem_wready || bus.dmem_rready) begin
                    op_s    = bus.dmem_wready ? OP_WRITE : OP_READ;
                    addr_s  = bus.dmem_wready ? bus.dmem_waddr : bus.dmem_raddr;
                    cnt_s   = CNT_LOAD;
                    state_s = (WAIT_CYCLES == 32'd1) ? ST_ACK : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!op_ready_s) begin
                    state_s = ST_IDLE;
                end else if (cnt_r <= 4'd1) begin
                    cnt_s   = 4'd0;
                    state_s = ST_ACK;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                    state_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
                if (op_ready_s && (op_r == OP_WRITE)) begin
                    wvalid_s = 1'b1;
                end else if (op_ready_s) begin
                    rvalid_s = 1'b1;
                end else begin
                    wvalid_s = 1'b0;
                    rvalid_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Accepts are forced low while reset is held, even with a request already pending
    assign wacc_s     = wvalid_s & ~reset;
    assign racc_s     = rvalid_s & ~reset;
    assign offset_s   = addr_offset(acc_addr_s, DMEM_BASE);
    assign in_range_s = (offset_s < SPAN);

    // FSM, counter, latched request and response flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            op_r    <= OP_READ;
            cnt_r   <= 4'd0;
            addr_r  <= 32'h0000_0000;
            rresp_r <= 1'b1;
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            rresp_r <= racc_s ? in_range_s : rresp_r;
        end
    end

    dmem_responder_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (wacc_s & in_range_s),
        .wstrb  (bus.dmem_wstrb),
        .wdata  (bus.dmem_wdata),
        .re     (racc_s),
        .rd_clr (~in_range_s),
        .idx    (offset_s[IDX_W+1:2]),
        .rdata  (bus.dmem_rdata)
    );

    assign bus.dmem_wvalid = wacc_s;
    assign bus.dmem_rvalid = racc_s;
    assign bus.dmem_rresp  = rresp_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a zero-wait instance and a three-wait-state instance checked against
// a word-array model, with read expectations queued at accept and compared one edge later.
module tb_dmem_responder;

    localparam int unsigned D0    = 64;
    localparam int unsigned D3    = 16;
    localparam logic [31:0] B0    = 32'h0000_0000;
    localparam logic [31:0] B3    = 32'h0000_1000;
    localparam logic [31:0] SPAN0 = 32'd256;
    localparam logic [31:0] SPAN3 = 32'd64;

    typedef struct packed {
        logic [31:0] data;
        logic        resp;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst0, rst3;
    always #5 clk = ~clk;

    dmem_responder_if bus0();
    dmem_responder_if bus3();

    dmem_responder #(.DEPTH(D0), .WAIT_CYCLES(0), .DMEM_BASE(B0)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    dmem_responder #(.DEPTH(D3), .WAIT_CYCLES(3), .DMEM_BASE(B3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));

    rd_exp_t     sb0[$];
    rd_exp_t     sb3[$];
    logic [31:0] mem0 [D0];
    logic [31:0] mem3 [D3];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic write0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output bit acc);
        @(posedge clk); #1;
        bus0.dmem_waddr = a; bus0.dmem_wdata = d; bus0.dmem_wstrb = s; bus0.dmem_wready = 1'b1;
        @(negedge clk);
        acc = bus0.dmem_wvalid;
        if (acc && ((a - B0) < SPAN0)) mem0[((a - B0) >> 2) % D0] = merge(mem0[((a - B0) >> 2) % D0], d, s);
        @(posedge clk); #1;
        bus0.dmem_wready = 1'b0;
    endtask

    task automatic read0(input logic [31:0] a, output bit acc);
        rd_exp_t e;
        @(posedge clk); #1;
        bus0.dmem_raddr = a; bus0.dmem_rready = 1'b1;
        @(negedge clk);
        acc = bus0.dmem_rvalid;
        e.resp = ((a - B0) < SPAN0);
        e.data = e.resp ? mem0[((a - B0) >> 2) % D0] : 32'h0000_0000;
        if (acc) sb0.push_back(e);
        @(posedge clk); #1;
        bus0.dmem_rready = 1'b0;
    endtask

    task automatic write3(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
        @(posedge clk); #1;
        bus3.dmem_waddr = a; bus3.dmem_wdata = d; bus3.dmem_wstrb = s; bus3.dmem_wready = 1'b1;
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus3.dmem_wvalid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat >= 0) begin
            if ((a - B3) < SPAN3) mem3[((a - B3) >> 2) % D3] = merge(mem3[((a - B3) >> 2) % D3], d, s);
            @(posedge clk); #1;
        end
        bus3.dmem_wready = 1'b0;
    endtask

    task automatic read3(input logic [31:0] a, output int lat);
        rd_exp_t e;
        @(posedge clk); #1;
        bus3.dmem_raddr = a; bus3.dmem_rready = 1'b1;
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus3.dmem_rvalid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat >= 0) begin
            e.resp = ((a - B3) < SPAN3);
            e.data = e.resp ? mem3[((a - B3) >> 2) % D3] : 32'h0000_0000;
            sb3.push_back(e);
            @(posedge clk); #1;
        end
        bus3.dmem_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst3 = 1'b1;
        bus0.dmem_waddr = 32'h0; bus0.dmem_wdata = 32'h0; bus0.dmem_wstrb = 4'h0; bus0.dmem_raddr = 32'h0;
        bus3.dmem_waddr = 32'h0; bus3.dmem_wdata = 32'h0; bus3.dmem_wstrb = 4'h0; bus3.dmem_raddr = B3;
        bus0.dmem_wready = 1'b1; bus0.dmem_rready = 1'b1;
        bus3.dmem_wready = 1'b1; bus3.dmem_rready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus0.dmem_wvalid, bus0.dmem_rvalid, bus0.dmem_rresp, bus0.dmem_rdata} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_dut0 got wv=%b rv=%b resp=%b data=%h exp 0 0 1 00000000",
                     bus0.dmem_wvalid, bus0.dmem_rvalid, bus0.dmem_rresp, bus0.dmem_rdata);
        end
        checks++;
        if ({bus3.dmem_wvalid, bus3.dmem_rvalid, bus3.dmem_rresp, bus3.dmem_rdata} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_dut3 got wv=%b rv=%b resp=%b data=%h exp 0 0 1 00000000",
                     bus3.dmem_wvalid, bus3.dmem_rvalid, bus3.dmem_rresp, bus3.dmem_rdata);
        end
        @(posedge clk); #1;
        bus0.dmem_wready = 1'b0; bus0.dmem_rready = 1'b0;
        bus3.dmem_wready = 1'b0; bus3.dmem_rready = 1'b0;
        rst0 = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_zero_wait();
        bit acc;
        rd_exp_t e;
        write0(32'h10, 32'hDEAD_BEEF, 4'hF, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL zw_write_accept got %b exp 1", acc); end
        read0(32'h10, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL zw_read_accept got %b exp 1", acc); end
        if (sb0.size() != 0) begin
            e = sb0.pop_front();
            checks++;
            if ({bus0.dmem_rdata, bus0.dmem_rresp} !== {e.data, e.resp}) begin
                errors++;
                $display("FAIL zw_read_data got %h/%b exp %h/%b", bus0.dmem_rdata, bus0.dmem_rresp, e.data, e.resp);
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (bus0.dmem_rdata !== e.data) begin
                errors++;
                $display("FAIL zw_read_hold got %h exp %h", bus0.dmem_rdata, e.data);
            end
        end
    endtask

    task automatic test_strobes();
        bit acc;
        rd_exp_t e;
        write0(32'h14, 32'h1122_3344, 4'hF, acc);
        write0(32'h14, 32'hAABB_CCDD, 4'b0101, acc);
        read0(32'h14, acc);
        checks++;
        if (bus0.dmem_rdata !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strobe_merge got %h exp 11bb33dd", bus0.dmem_rdata);
        end
        if (sb0.size() != 0) void'(sb0.pop_front());
        write0(32'h14, 32'hFFFF_FFFF, 4'h0, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL strobe_zero_accept got %b exp 1", acc); end
        read0(32'h14, acc);
        if (sb0.size() != 0) begin
            e = sb0.pop_front();
            checks++;
            if (bus0.dmem_rdata !== e.data) begin
                errors++;
                $display("FAIL strobe_zero_noop got %h exp %h", bus0.dmem_rdata, e.data);
            end
        end
    endtask

    task automatic test_collision();
        rd_exp_t e;
        @(posedge clk); #1;
        bus0.dmem_waddr = 32'h20; bus0.dmem_wdata = 32'd5; bus0.dmem_wstrb = 4'hF; bus0.dmem_wready = 1'b1;
        bus0.dmem_raddr = 32'h20; bus0.dmem_rready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus0.dmem_wvalid, bus0.dmem_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL collide_grant got wv=%b rv=%b exp 1 0", bus0.dmem_wvalid, bus0.dmem_rvalid);
        end
        mem0[8] = merge(mem0[8], 32'd5, 4'hF);
        @(posedge clk); #1;
        bus0.dmem_wready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.dmem_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL collide_read_accept got %b exp 1", bus0.dmem_rvalid);
        end
        e.data = mem0[8]; e.resp = 1'b1;
        sb0.push_back(e);
        @(posedge clk); #1;
        bus0.dmem_rready = 1'b0;
        e = sb0.pop_front();
        checks++;
        if ({bus0.dmem_rdata, bus0.dmem_rresp} !== {e.data, e.resp}) begin
            errors++;
            $display("FAIL collide_read_data got %h/%b exp %h/%b", bus0.dmem_rdata, bus0.dmem_rresp, e.data, e.resp);
        end
    endtask

    task automatic test_range();
        bit acc;
        int lat;
        rd_exp_t e;
        logic [31:0] addrs [4];
        addrs[0] = 32'h100; addrs[1] = 32'h0; addrs[2] = 32'hFC; addrs[3] = 32'h104;
        write0(32'h0, 32'h0BAD_F00D, 4'hF, acc);
        write0(32'hFC, 32'hCAFE_F00D, 4'hF, acc);
        write0(32'h100, 32'h1234_5678, 4'hF, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL range_oor_write_accept got %b exp 1", acc); end
        for (int i = 0; i < 4; i++) begin
            read0(addrs[i], acc);
            if (sb0.size() != 0) begin
                e = sb0.pop_front();
                checks++;
                if ({bus0.dmem_rdata, bus0.dmem_rresp} !== {e.data, e.resp}) begin
                    errors++;
                    $display("FAIL range_read_%0d got %h/%b exp %h/%b", i, bus0.dmem_rdata, bus0.dmem_rresp, e.data, e.resp);
                end
            end else begin
                checks++; errors++;
                $display("FAIL range_read_accept_%0d got 0 exp 1", i);
            end
        end
        read3(32'h0000_0FFC, lat);
        if (sb3.size() != 0) begin
            e = sb3.pop_front();
            checks++;
            if ({bus3.dmem_rdata, bus3.dmem_rresp} !== {e.data, e.resp}) begin
                errors++;
                $display("FAIL range_below_base got %h/%b exp %h/%b", bus3.dmem_rdata, bus3.dmem_rresp, e.data, e.resp);
            end
        end else begin
            checks++; errors++;
            $display("FAIL range_below_base_accept got timeout exp accept");
        end
    endtask

    task automatic test_wait_states();
        int lat;
        rd_exp_t e;
        write3(B3 + 32'h8, 32'h5A5A_1234, 4'hF, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL wait_write_latency got %0d exp 3", lat); end
        @(posedge clk); #1;
        bus3.dmem_raddr = B3 + 32'h8; bus3.dmem_rready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus3.dmem_rvalid !== (c == 3)) begin
                errors++;
                $display("FAIL wait_rvalid_cycle%0d got %b exp %b", c, bus3.dmem_rvalid, (c == 3));
            end
            if (bus3.dmem_rvalid) begin
                e.data = mem3[2]; e.resp = 1'b1;
                sb3.push_back(e);
            end
            @(posedge clk); #1;
        end
        bus3.dmem_rready = 1'b0;
        if (sb3.size() != 0) begin
            e = sb3.pop_front();
            checks++;
            if ({bus3.dmem_rdata, bus3.dmem_rresp} !== {e.data, e.resp}) begin
                errors++;
                $display("FAIL wait_read_data got %h/%b exp %h/%b", bus3.dmem_rdata, bus3.dmem_rresp, e.data, e.resp);
            end
        end
    endtask

    task automatic test_abort();
        int lat;
        rd_exp_t e;
        logic [31:0] prev;
        prev = bus3.dmem_rdata;
        @(posedge clk); #1;
        bus3.dmem_waddr = B3 + 32'h8; bus3.dmem_wdata = 32'hFFFF_FFFF; bus3.dmem_wstrb = 4'hF; bus3.dmem_wready = 1'b1;
        bus3.dmem_raddr = B3 + 32'h8;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) bus3.dmem_wready = 1'b0;
            if (c == 3) bus3.dmem_rready = 1'b1;
            if (c == 5) bus3.dmem_rready = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus3.dmem_wvalid, bus3.dmem_rvalid} !== 2'b00) begin
                errors++;
                $display("FAIL abort_valid_cycle%0d got wv=%b rv=%b exp 0 0", c, bus3.dmem_wvalid, bus3.dmem_rvalid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus3.dmem_rdata !== prev) begin
            errors++;
            $display("FAIL abort_rdata_hold got %h exp %h", bus3.dmem_rdata, prev);
        end
        read3(B3 + 32'h8, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL abort_next_latency got %0d exp 3", lat); end
        if (sb3.size() != 0) begin
            e = sb3.pop_front();
            checks++;
            if (bus3.dmem_rdata !== e.data) begin
                errors++;
                $display("FAIL abort_no_write got %h exp %h", bus3.dmem_rdata, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        rd_exp_t e;
        @(posedge clk); #1;
        bus3.dmem_waddr = B3 + 32'h10; bus3.dmem_wdata = 32'h0000_0077; bus3.dmem_wstrb = 4'hF; bus3.dmem_wready = 1'b1;
        bus3.dmem_raddr = B3 + 32'h10; bus3.dmem_rready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) bus3.dmem_wready = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus3.dmem_wvalid, bus3.dmem_rvalid} !== {(c == 3), (c == 7)}) begin
                errors++;
                $display("FAIL b2b_cycle%0d got wv=%b rv=%b exp %b %b", c, bus3.dmem_wvalid, bus3.dmem_rvalid, (c == 3), (c == 7));
            end
            if (bus3.dmem_wvalid) mem3[4] = merge(mem3[4], 32'h0000_0077, 4'hF);
            if (bus3.dmem_rvalid) begin
                e.data = mem3[4]; e.resp = 1'b1;
                sb3.push_back(e);
            end
            @(posedge clk); #1;
        end
        bus3.dmem_rready = 1'b0;
        if (sb3.size() != 0) begin
            e = sb3.pop_front();
            checks++;
            if ({bus3.dmem_rdata, bus3.dmem_rresp} !== {e.data, e.resp}) begin
                errors++;
                $display("FAIL b2b_read_data got %h/%b exp %h/%b", bus3.dmem_rdata, bus3.dmem_rresp, e.data, e.resp);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        rd_exp_t e;
        @(posedge clk); #1;
        bus3.dmem_raddr = B3 + 32'h8; bus3.dmem_rready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        checks++;
        if ({bus3.dmem_wvalid, bus3.dmem_rvalid, bus3.dmem_rresp, bus3.dmem_rdata} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rstwait_outputs got wv=%b rv=%b resp=%b data=%h exp 0 0 1 00000000",
                     bus3.dmem_wvalid, bus3.dmem_rvalid, bus3.dmem_rresp, bus3.dmem_rdata);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus3.dmem_rvalid !== 1'b0) begin errors++; $display("FAIL rstwait_held_rvalid got %b exp 0", bus3.dmem_rvalid); end
        rst3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus3.dmem_rvalid !== (c == 3)) begin
                errors++;
                $display("FAIL rstwait_rvalid_cycle%0d got %b exp %b", c, bus3.dmem_rvalid, (c == 3));
            end
            if (bus3.dmem_rvalid) begin
                e.data = mem3[2]; e.resp = 1'b1;
                sb3.push_back(e);
            end
            @(posedge clk); #1;
        end
        bus3.dmem_rready = 1'b0;
        if (sb3.size() != 0) begin
            e = sb3.pop_front();
            checks++;
            if ({bus3.dmem_rdata, bus3.dmem_rresp} !== {e.data, e.resp}) begin
                errors++;
                $display("FAIL rstwait_read_data got %h/%b exp %h/%b", bus3.dmem_rdata, bus3.dmem_rresp, e.data, e.resp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_strobes();
        test_collision();
        test_range();
        test_wait_states();
        test_abort();
        test_back_to_back();
        test_reset_in_wait();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
